fsmotor_stepctl: RTL and testbench
==================================

# fsmotor_stepctl

Step-sequencing controller for one stepper-motor channel. It accepts a move command (direction, step count, half-period, microstep mode) from the register/software side and generates the `drive`/`dir`/`xen`/`xrst`/`ms` pin group. That group feeds one `sN_*` slot of the motor pin-routing block. The controller counts steps, tracks a signed position, and stops early on the zero-position detector (`zpd`) when moving toward home.

## Interface
- `C_MICROSTEP_WIDTH`, 3: width of the microstep select.
- `C_STEP_NUMBER_WIDTH`, 16: width of the step count and remaining-step counter.
- `C_SPEED_DATA_WIDTH`, 16: width of the half-period (in clocks) of `drive`.
- `C_POS_WIDTH`, 24: width of the signed position counter.
- `C_DIR_SETUP`, 4: clocks `dir` is held stable before the first `drive` rise (≥1).
- `C_ZPD_ACTIVE`, 1: level of `zpd` meaning "at zero".
- `clk`  in  1  core clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_start`  in  1  one-cycle start pulse; ignored unless `busy`=0.
- `req_stop`  in  1  one-cycle abort pulse; honoured only while `busy`=1.
- `req_dir`  in  1  1 = away from zero (position +1/step), 0 = toward zero.
- `req_step`  in  C_STEP_NUMBER_WIDTH  steps to move.
- `req_speed`  in  C_SPEED_DATA_WIDTH  half-period in clocks; 0 treated as 1.
- `req_ms`  in  C_MICROSTEP_WIDTH  microstep mode for this move.
- `cfg_en`  in  1  keep the driver enabled while idle.
- `cfg_drv_rst`  in  1  hold the driver chip in reset.
- `zpd`  in  1  raw zero-position detector (asynchronous to `clk`).
- `xen`  out  1  driver enable, active-low.
- `xrst`  out  1  driver reset, active-low.
- `ms`  out  C_MICROSTEP_WIDTH  microstep select.
- `drive`  out  1  step pulse.
- `dir`  out  1  direction pin.
- `busy`  out  1  move in progress.
- `done`  out  1  one-cycle pulse on move end.
- `zpd_hit`  out  1  sticky; last move ended on `zpd`. Cleared by the next accepted start.
- `remain`  out  C_STEP_NUMBER_WIDTH  steps not yet issued.
- `position`  out  C_POS_WIDTH  signed position, two's complement.

## Operation
- `zpd` passes through a 2-FF synchroniser; `zpd_s` denotes the synchronised level compared against `C_ZPD_ACTIVE`.
- State machine states: IDLE, SETUP, HIGH, LOW.
- IDLE:
  - On `req_start`, latch dir/ms/speed into internal registers, load `remain` with `req_step`, and clear `zpd_hit`.
  - If `req_step`=0, pulse `done` next cycle and stay in IDLE.
  - Otherwise go to SETUP.
- SETUP: `dir`/`ms` are driven from the latched values; after C_DIR_SETUP clocks, go to HIGH.
- HIGH:
  - `drive`=1 for `speed` clocks.
  - On entry, decrement `remain` and update `position` (+1 if dir=1, −1 if dir=0, wrapping modulo 2^C_POS_WIDTH).
- LOW: `drive`=0 for `speed` clocks. At the end of the phase:
  - Stop condition true → IDLE and pulse `done`.
  - Otherwise → HIGH.
- Stop conditions are evaluated at the end of LOW, in this priority order:
  - zpd: dir=0 and `zpd_s` active. Set `position`=0 and `zpd_hit`=1, overriding that step's decrement.
  - abort: `req_stop` was seen during the move; a pending-stop flag is latched.
  - count: `remain`=0.
- A start toward zero with `zpd_s` already active still issues exactly one step, then stops with `zpd_hit`=1.
- `req_stop` during SETUP ends the move at the end of SETUP. No step is issued and `position` is unchanged.
- `req_start` while `busy`=1 is ignored. `req_stop` while idle is ignored.
- `xen` = ~(`busy` | `cfg_en`).
- `xrst` = ~(`cfg_drv_rst` | `rst`), driven combinationally so the driver is reset during `rst`.
- `ms` and `dir` change only in IDLE on start acceptance; they stay stable through the whole move.

## Timing
- Reset values:
  - State IDLE.
  - `drive`=0, `dir`=0, `ms`=0, `busy`=0, `done`=0, `zpd_hit`=0, `remain`=0, `position`=0.
  - `xen`=1, `xrst`=0 while `rst` is high.
- Start accepted at edge T:
  - `busy`=1 and `dir`/`ms` valid at T+1.
  - First `drive` rise at T+1+C_DIR_SETUP.
- Step period is 2·`speed` clocks.
- `done` is high in the cycle `busy` falls, and `drive` is 0 in that cycle.
- The total move of N steps lasts C_DIR_SETUP + 2·N·`speed` clocks from `busy` rise to `busy` fall.
- `zpd` latency to decision: 2 clocks (synchroniser) plus the remainder of the current step.
- An asynchronous `rst` mid-move immediately returns all outputs to their reset values. `drive` may truncate; this is acceptable.

## Test plan
- Start dir=1, step=3, speed=2, C_DIR_SETUP=4:
  - `drive` rises at T+5, T+9 and T+13, each high for 2 clocks.
  - `done` at T+17; `position`=3, `remain`=0.
- Start dir=0, step=100, speed=1 from position 0; assert `zpd` during step 5:
  - Move ends within 2 steps after synchroniser latency.
  - `position`=0, `zpd_hit`=1, `remain`>0.
- Start step=10, pulse `req_stop` during step 3's HIGH phase:
  - Exactly 3 `drive` pulses.
  - `done` after LOW completes; `remain`=7, `position`=3.
- Start with step=0: no `drive` pulse; `done` one cycle after start; `busy` stays 0.
- Pulse `req_start` mid-move with different dir/ms: ignored, and `dir`/`ms` stay unchanged.
- Assert `rst` mid-HIGH:
  - `drive`=0, `xrst`=0, `xen`=1 and `position`=0 immediately.
  - A new move after release behaves normally.

Source files
------------

// File: rtl/fsmotor_stepctl.sv
// -----------------------------------------------------------------------------
// fsmotor_stepctl
//
// Step-sequencing controller for a single stepper-motor channel. A move
// command (direction, step count, half-period, microstep mode) is accepted
// while idle. The controller then produces the drive/dir/xen/xrst/ms pin
// group for one motor slot. It counts steps, keeps a signed position and
// stops early on the zero-position detector when moving toward home.
//
// Ports
//   clk          core clock
//   rst          asynchronous active-high reset
//   req_start    one-cycle start pulse (accepted only while idle)
//   req_stop     one-cycle abort pulse (honoured only while busy)
//   req_dir      1 = away from zero (+1 per step), 0 = toward zero
//   req_step     number of steps to move
//   req_speed    half-period of drive in clocks (0 behaves as 1)
//   req_ms       microstep mode for the move
//   cfg_en       keep the driver enabled while idle
//   cfg_drv_rst  hold the driver chip in reset
//   zpd          raw zero-position detector (asynchronous)
//   xen          driver enable, active-low
//   xrst         driver reset, active-low
//   ms           microstep select
//   drive        step pulse
//   dir          direction pin
//   busy         move in progress
//   done         one-cycle pulse when a move ends
//   zpd_hit      sticky: last move ended on the zero detector
//   remain       steps not yet issued
//   position     signed position, two's complement
// -----------------------------------------------------------------------------
module fsmotor_stepctl #(
    parameter int C_MICROSTEP_WIDTH   = 3,
    parameter int C_STEP_NUMBER_WIDTH = 16,
    parameter int C_SPEED_DATA_WIDTH  = 16,
    parameter int C_POS_WIDTH         = 24,
    parameter int C_DIR_SETUP         = 4,
    parameter bit C_ZPD_ACTIVE        = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_start,
    input  logic                           req_stop,
    input  logic                           req_dir,
    input  logic [C_STEP_NUMBER_WIDTH-1:0] req_step,
    input  logic [C_SPEED_DATA_WIDTH-1:0]  req_speed,
    input  logic [C_MICROSTEP_WIDTH-1:0]   req_ms,
    input  logic                           cfg_en,
    input  logic                           cfg_drv_rst,
    input  logic                           zpd,
    output logic                           xen,
    output logic                           xrst,
    output logic [C_MICROSTEP_WIDTH-1:0]   ms,
    output logic                           drive,
    output logic                           dir,
    output logic                           busy,
    output logic                           done,
    output logic                           zpd_hit,
    output logic [C_STEP_NUMBER_WIDTH-1:0] remain,
    output logic [C_POS_WIDTH-1:0]         position
);

    // The phase counter times both the direction setup interval and the
    // drive half-periods, so it is sized for whichever needs more bits.
    localparam int SETUP_W = (C_DIR_SETUP > 1) ? $clog2(C_DIR_SETUP) : 1;
    localparam int CNT_W   = (SETUP_W > C_SPEED_DATA_WIDTH) ? SETUP_W : C_SPEED_DATA_WIDTH;
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(C_DIR_SETUP - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW
    } state_t;

    state_t                          state;
    logic [CNT_W-1:0]                phase_cnt;
    logic [C_SPEED_DATA_WIDTH-1:0]   speed_lat;
    logic                            stop_pending;
    logic [1:0]                      zpd_sync;

    logic                            zpd_s;
    logic                            stop_now;
    logic [CNT_W-1:0]                speed_load;
    logic [C_POS_WIDTH-1:0]          position_step;

    // ------------------------------------------------------------------
    // Zero detector synchroniser (two flops; the raw input is asynchronous)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zpd_sync <= 2'b00;
        end else begin
            zpd_sync <= {zpd_sync[0], zpd};
        end
    end

    assign zpd_s = (zpd_sync[1] == C_ZPD_ACTIVE);

    // An abort pulse arriving in the very cycle a phase ends still counts,
    // so the latched flag is OR-ed with the live request.
    assign stop_now = stop_pending | req_stop;

    // Each phase lasts speed_lat clocks; the counter runs down to zero.
    assign speed_load = CNT_W'(speed_lat) - CNT_W'(1);

    // Position after the step that is about to be issued (wraps naturally).
    assign position_step = dir ? (position + C_POS_WIDTH'(1))
                               : (position - C_POS_WIDTH'(1));

    // ------------------------------------------------------------------
    // Move sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            phase_cnt    <= '0;
            speed_lat    <= '0;
            stop_pending <= 1'b0;
            drive        <= 1'b0;
            dir          <= 1'b0;
            ms           <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            zpd_hit      <= 1'b0;
            remain       <= '0;
            position     <= '0;
        end else begin
            done <= 1'b0;

            if (busy && req_stop) begin
                stop_pending <= 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    if (req_start) begin
                        dir          <= req_dir;
                        ms           <= req_ms;
                        speed_lat    <= (req_speed == '0) ? C_SPEED_DATA_WIDTH'(1) : req_speed;
                        remain       <= req_step;
                        zpd_hit      <= 1'b0;
                        stop_pending <= 1'b0;
                        if (req_step == '0) begin
                            // Empty move: acknowledge without ever going busy.
                            done <= 1'b1;
                        end else begin
                            state     <= ST_SETUP;
                            busy      <= 1'b1;
                            phase_cnt <= SETUP_LOAD;
                        end
                    end
                end

                ST_SETUP: begin
                    if (phase_cnt == '0) begin
                        if (stop_now) begin
                            // Aborted before the first step: nothing issued.
                            state        <= ST_IDLE;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            stop_pending <= 1'b0;
                        end else begin
                            state     <= ST_HIGH;
                            drive     <= 1'b1;
                            phase_cnt <= speed_load;
                            remain    <= remain - C_STEP_NUMBER_WIDTH'(1);
                            position  <= position_step;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - CNT_W'(1);
                    end
                end

                ST_HIGH: begin
                    if (phase_cnt == '0) begin
                        state     <= ST_LOW;
                        drive     <= 1'b0;
                        phase_cnt <= speed_load;
                    end else begin
                        phase_cnt <= phase_cnt - CNT_W'(1);
                    end
                end

                ST_LOW: begin
                    if (phase_cnt == '0) begin
                        if (!dir && zpd_s) begin
                            // Home reached: the position is redefined as zero,
                            // replacing the decrement applied on this step.
                            state        <= ST_IDLE;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            stop_pending <= 1'b0;
                            position     <= '0;
                            zpd_hit      <= 1'b1;
                        end else if (stop_now || (remain == '0)) begin
                            state        <= ST_IDLE;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            stop_pending <= 1'b0;
                        end else begin
                            state     <= ST_HIGH;
                            drive     <= 1'b1;
                            phase_cnt <= speed_load;
                            remain    <= remain - C_STEP_NUMBER_WIDTH'(1);
                            position  <= position_step;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - CNT_W'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Driver control pins. Both are gated by rst directly so the driver is
    // disabled and held in reset for the whole reset interval.
    // ------------------------------------------------------------------
    assign xen  = ~((busy | cfg_en) & ~rst);
    assign xrst = ~(cfg_drv_rst | rst);

endmodule

// File: tb/tb_fsmotor_stepctl.sv
module tb_fsmotor_stepctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_start;
    logic        req_stop;
    logic        req_dir;
    logic [15:0] req_step;
    logic [15:0] req_speed;
    logic [2:0]  req_ms;
    logic        cfg_en;
    logic        cfg_drv_rst;
    logic        zpd;
    logic        xen;
    logic        xrst;
    logic [2:0]  ms;
    logic        drive;
    logic        dir;
    logic        busy;
    logic        done;
    logic        zpd_hit;
    logic [15:0] remain;
    logic [23:0] position;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int pulses;
        int high_cycles;
        int remain;
        int position;
        int zpd_hit;
        int done_k;
        int first_k;
    } exp_t;

    exp_t sb_q[$];
    logic [23:0] exp_pos;

    always #5 clk = ~clk;

    fsmotor_stepctl dut (
        .clk         (clk),
        .rst         (rst),
        .req_start   (req_start),
        .req_stop    (req_stop),
        .req_dir     (req_dir),
        .req_step    (req_step),
        .req_speed   (req_speed),
        .req_ms      (req_ms),
        .cfg_en      (cfg_en),
        .cfg_drv_rst (cfg_drv_rst),
        .zpd         (zpd),
        .xen         (xen),
        .xrst        (xrst),
        .ms          (ms),
        .drive       (drive),
        .dir         (dir),
        .busy        (busy),
        .done        (done),
        .zpd_hit     (zpd_hit),
        .remain      (remain),
        .position    (position)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int pulses, input int highs, input int rem,
                            input int pos, input int zh, input int done_k, input int first_k);
        exp_t e;
        e.pulses      = pulses;
        e.high_cycles = highs;
        e.remain      = rem;
        e.position    = pos;
        e.zpd_hit     = zh;
        e.done_k      = done_k;
        e.first_k     = first_k;
        sb_q.push_back(e);
    endtask

    // act: 0 none, 1 stop at rise #act_at, 2 raise zpd at rise #act_at,
    //      3 stop at cycle act_at, 4 conflicting start at cycle act_at
    task automatic run_move(input string name, input bit d, input int step, input int spd,
                            input logic [2:0] m, input int act, input int act_at);
        exp_t e;
        int   k, rises, highs, busy_n, first_k, bad_dm, bad_xen;
        bit   prev_drive, seen_done;
        @(negedge clk);
        req_dir   = d;
        req_step  = 16'(step);
        req_speed = 16'(spd);
        req_ms    = m;
        req_start = 1'b1;
        @(negedge clk);
        req_start = 1'b0;
        k = 1; rises = 0; highs = 0; busy_n = 0; first_k = -1; bad_dm = 0; bad_xen = 0;
        prev_drive = 1'b0; seen_done = 1'b0;
        while (k <= 3000) begin
            req_stop  = 1'b0;
            req_start = 1'b0;
            if (drive && !prev_drive) begin
                rises++;
                if (first_k < 0) first_k = k;
                if (act == 1 && rises == act_at) req_stop = 1'b1;
                if (act == 2 && rises == act_at) zpd = 1'b1;
            end
            prev_drive = drive;
            if (drive) highs++;
            if (busy) busy_n++;
            if (dir !== d || ms !== m) bad_dm++;
            if (xen !== ~(busy | cfg_en)) bad_xen++;
            if (act == 3 && k == act_at) req_stop = 1'b1;
            if (act == 4 && k == act_at) begin
                req_dir   = ~d;
                req_ms    = ~m;
                req_step  = 16'd1;
                req_start = 1'b1;
            end
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            @(negedge clk);
            k++;
        end
        req_stop  = 1'b0;
        req_start = 1'b0;
        chk({name, "/done_seen"}, 32'(seen_done), 32'd1);
        if (sb_q.size() == 0) begin
            chk({name, "/scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({name, "/pulses"},     32'(rises),    32'(e.pulses));
            chk({name, "/high_clks"},  32'(highs),    32'(e.high_cycles));
            chk({name, "/remain"},     32'(remain),   32'(e.remain));
            chk({name, "/position"},   32'(position), 32'(e.position) & 32'hFFFFFF);
            chk({name, "/zpd_hit"},    32'(zpd_hit),  32'(e.zpd_hit));
            chk({name, "/done_cycle"}, 32'(k),        32'(e.done_k));
            chk({name, "/first_rise"}, 32'(first_k),  32'(e.first_k));
            chk({name, "/busy_clks"},  32'(busy_n),   32'(e.done_k - 1));
            $display("move %s: pulses=%0d done_cycle=%0d remain=%0d position=%0h zpd_hit=%0b",
                     name, rises, k, remain, position, zpd_hit);
        end
        chk({name, "/drive_at_done"}, 32'(drive), 32'd0);
        chk({name, "/busy_at_done"},  32'(busy),  32'd0);
        chk({name, "/dir_ms_stable"}, 32'(bad_dm),  32'd0);
        chk({name, "/xen_tracks"},    32'(bad_xen), 32'd0);
        @(negedge clk);
        chk({name, "/done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_start = 1'b0; req_stop = 1'b0; req_dir = 1'b0;
        req_step = '0; req_speed = '0; req_ms = '0;
        cfg_en = 1'b0; cfg_drv_rst = 1'b0; zpd = 1'b0;
        exp_pos = '0;
        #1;
        chk("reset/xrst", 32'(xrst), 32'd0);
        chk("reset/xen", 32'(xen), 32'd1);
        chk("reset/outputs", {drive, dir, ms, busy, done, zpd_hit}, 32'd0);
        chk("reset/remain", 32'(remain), 32'd0);
        chk("reset/position", 32'(position), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle/xrst", 32'(xrst), 32'd1);
        chk("idle/xen", 32'(xen), 32'd1);

        // Basic forward move: rises at T+5,9,13; done at T+17.
        exp_pos = exp_pos + 24'd3;
        push_exp(3, 6, 0, int'(exp_pos), 0, 17, 5);
        run_move("fwd3", 1'b1, 3, 2, 3'd1, 0, 0);

        // Homing: zpd raised after the 5th rise; synchroniser lets step 6 out.
        exp_pos = '0;
        push_exp(6, 6, 94, 0, 1, 17, 5);
        run_move("zpd_home", 1'b0, 100, 1, 3'd2, 2, 5);

        // Detector already active: exactly one step then stop.
        push_exp(1, 1, 4, 0, 1, 7, 5);
        run_move("zpd_at_start", 1'b0, 5, 1, 3'd3, 0, 0);
        zpd = 1'b0;
        repeat (4) @(negedge clk);

        // Zero-step move: done next cycle, never busy, zpd_hit cleared.
        push_exp(0, 0, 0, int'(exp_pos), 0, 1, -1);
        run_move("zero_step", 1'b1, 0, 2, 3'd4, 0, 0);

        // Abort during the 3rd HIGH phase.
        exp_pos = exp_pos + 24'd3;
        push_exp(3, 6, 7, int'(exp_pos), 0, 17, 5);
        run_move("abort_high", 1'b1, 10, 2, 3'd5, 1, 3);

        // Abort during SETUP: no steps, ends at the end of SETUP.
        push_exp(0, 0, 5, int'(exp_pos), 0, 5, -1);
        run_move("abort_setup", 1'b0, 5, 2, 3'd6, 3, 2);

        // Conflicting start mid-move is ignored.
        exp_pos = exp_pos + 24'd4;
        push_exp(4, 4, 0, int'(exp_pos), 0, 13, 5);
        run_move("restart_ignored", 1'b1, 4, 1, 3'd5, 4, 8);

        // Stop pulse while idle must not leak into the next move; speed 0 acts as 1.
        @(negedge clk); req_stop = 1'b1;
        @(negedge clk); req_stop = 1'b0;
        exp_pos = exp_pos - 24'd2;
        push_exp(2, 2, 0, int'(exp_pos), 0, 9, 5);
        run_move("speed0", 1'b0, 2, 0, 3'd0, 0, 0);

        // Reset in the middle of a HIGH phase.
        cfg_en = 1'b1;
        @(negedge clk);
        req_dir = 1'b1; req_step = 16'd10; req_speed = 16'd3; req_ms = 3'd2; req_start = 1'b1;
        @(negedge clk);
        req_start = 1'b0;
        for (int i = 0; i < 50 && !drive; i++) @(negedge clk);
        chk("rst_mid/drive_reached", 32'(drive), 32'd1);
        chk("rst_mid/pos_before", 32'(position), 32'(exp_pos + 24'd1));
        rst = 1'b1;
        #1;
        chk("rst_mid/drive", 32'(drive), 32'd0);
        chk("rst_mid/xrst", 32'(xrst), 32'd0);
        chk("rst_mid/xen", 32'(xen), 32'd1);
        chk("rst_mid/position", 32'(position), 32'd0);
        chk("rst_mid/busy", 32'(busy), 32'd0);
        exp_pos = '0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("cfg_en/xen", 32'(xen), 32'd0);
        cfg_drv_rst = 1'b1;
        #1;
        chk("cfg_drv_rst/xrst", 32'(xrst), 32'd0);
        cfg_drv_rst = 1'b0;
        cfg_en = 1'b0;
        @(negedge clk);

        // Move after reset, wrapping below zero.
        exp_pos = exp_pos - 24'd2;
        push_exp(2, 2, 0, int'(exp_pos), 0, 9, 5);
        run_move("wrap", 1'b0, 2, 1, 3'd7, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
